// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared state and opcode definitions for the ALU arbiter
//
// Contents:
//   state_e  : arbiter FSM states (IDLE, EXEC, RESP)
//   opcode_e : 3-bit ALU opcodes; codes 4..7 are unassigned and give a zero result
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_LSH = 3'd1,
    OP_RSH = 3'd2,
    OP_XOR = 3'd3
  } opcode_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - purely combinational 8-bit-in / 16-bit-out ALU
//
// Ports:
//   op_i  [2:0]  opcode (opcode_e; other codes yield 0)
//   a_i   [7:0]  operand A, zero-extended to 16 bits
//   b_i   [7:0]  operand B (shift amount for LSH/RSH)
//   res_o [15:0] result
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] res_o
);

  logic [15:0] a_ext;
  logic [15:0] b_ext;
  logic        shift_oob;

  assign a_ext     = {8'h00, a_i};
  assign b_ext     = {8'h00, b_i};
  // Any shift of 16 or more clears every bit of the 16-bit result.
  assign shift_oob = (b_i >= 8'd16);

  always_comb begin
    res_o = 16'h0000;
    case (op_i)
      OP_ADD: res_o = a_ext + b_ext;
      OP_LSH: res_o = shift_oob ? 16'h0000 : (a_ext << b_i[3:0]);
      OP_RSH: res_o = shift_oob ? 16'h0000 : (a_ext >> b_i[3:0]);
      OP_XOR: res_o = a_ext ^ b_ext;
      default: res_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU, one transaction in flight
//
// Ports:
//   clk                 clock, all state on rising edge
//   rst                 synchronous active-high reset
//   req_vld[1:0]        requester i has an operation pending
//   req_rdy[1:0]        requester i accepted this cycle (combinational, IDLE only)
//   req_op0/1 [2:0]     opcodes per requester
//   req_a0/1, req_b0/1  8-bit operands per requester
//   rsp_vld[1:0]        result valid for the granted requester
//   rsp_rdy[1:0]        requester i accepts result
//   rsp_data [15:0]     registered result
//   busy                high whenever the FSM is not IDLE
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_vld,
  output logic [1:0]  req_rdy,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [7:0]  req_a0,
  input  logic [7:0]  req_a1,
  input  logic [7:0]  req_b0,
  input  logic [7:0]  req_b1,
  output logic [1:0]  rsp_vld,
  input  logic [1:0]  rsp_rdy,
  output logic [15:0] rsp_data,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [15:0] alu_res;
  logic        winner;

  // Tie goes to whoever was not served last; a lone requester always wins.
  assign winner = (req_vld == 2'b11) ? ~last_grant_q : req_vld[1];

  alu_arbiter_alu u_alu (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (alu_res)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    req_rdy      = 2'b00;
    rsp_vld      = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (|req_vld) begin
          req_rdy = winner ? 2'b10 : 2'b01;
          grant_d = winner;
          op_d    = winner ? req_op1 : req_op0;
          a_d     = winner ? req_a1  : req_a0;
          b_d     = winner ? req_b1  : req_b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = alu_res;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rsp_vld = grant_q ? 2'b10 : 2'b01;
        // Only the granted requester's rsp_rdy can complete the transaction.
        if (rsp_rdy[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // No handshake of either kind may be seen while reset is held.
    if (rst) begin
      req_rdy = 2'b00;
      rsp_vld = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= 3'd0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      rsp_data_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [2:0]  req_op0, req_op1;
  logic [7:0]  req_a0, req_a1, req_b0, req_b1;
  logic [15:0] rsp_data;
  logic        busy;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_op0  (req_op0),
    .req_op1  (req_op1),
    .req_a0   (req_a0),
    .req_a1   (req_a1),
    .req_b0   (req_b0),
    .req_b1   (req_b1),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference written from the opcode rules with plain integers.
  function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
    int r;
    r = 0;
    if (op == int'(OP_ADD))      r = a + b;
    else if (op == int'(OP_LSH)) r = (b >= 16) ? 0 : (a * (1 << b)) % 65536;
    else if (op == int'(OP_RSH)) r = (b >= 16) ? 0 : a / (1 << b);
    else if (op == int'(OP_XOR)) r = a ^ b;
    return r[15:0];
  endfunction

  // Requester side: a pending request is held until the DUT accepts it.
  bit          pend [2];
  logic [2:0]  p_op [2];
  logic [7:0]  p_a  [2];
  logic [7:0]  p_b  [2];
  logic [1:0]  rr;
  bit          rst_drv;

  // Reference model: one outstanding transaction, its age in cycles since grant.
  bit          m_busy;
  int          m_g;
  int          m_age;
  int          m_last;
  logic [15:0] m_data;
  int          grants [$];
  logic [15:0] results [$];

  // One cycle: drive at negedge, sample 1 time unit later, advance model, wait next negedge.
  task automatic tick();
    logic [1:0] exp_rdy, exp_vld;
    int w;
    rst     = rst_drv;
    rsp_rdy = rr;
    req_vld = {pend[1], pend[0]};
    req_op0 = p_op[0]; req_a0 = p_a[0]; req_b0 = p_b[0];
    req_op1 = p_op[1]; req_a1 = p_a[1]; req_b1 = p_b[1];
    #1;
    exp_rdy = 2'b00;
    exp_vld = 2'b00;
    w = 0;
    if (!rst_drv && !m_busy && req_vld != 2'b00) begin
      if (req_vld == 2'b11) w = 1 - m_last;
      else                  w = req_vld[1] ? 1 : 0;
      exp_rdy = (w == 1) ? 2'b10 : 2'b01;
    end
    if (!rst_drv && m_busy && m_age >= 2) exp_vld = (m_g == 1) ? 2'b10 : 2'b01;
    check("req_rdy", {30'd0, req_rdy}, {30'd0, exp_rdy});
    check("rsp_vld", {30'd0, rsp_vld}, {30'd0, exp_vld});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    if (exp_vld != 2'b00) check("rsp_data", {16'd0, rsp_data}, {16'd0, m_data});

    if (rst_drv) begin
      m_busy = 0;
      m_last = 1;
    end else if (exp_rdy != 2'b00) begin
      m_busy = 1;
      m_g    = w;
      m_age  = 1;
      m_data = ref_alu(int'(p_op[w]), int'(p_a[w]), int'(p_b[w]));
      grants.push_back(w);
    end else if (m_busy) begin
      if (m_age >= 2 && rr[m_g]) begin
        m_busy = 0;
        m_last = m_g;
        results.push_back(m_data);
      end else begin
        m_age++;
      end
    end
    for (int i = 0; i < 2; i++) if (req_rdy[i]) pend[i] = 0;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    pend[i] = 1; p_op[i] = op; p_a[i] = a; p_b[i] = b;
  endtask

  task automatic run_until_idle(input int limit);
    for (int i = 0; i < limit && (m_busy || pend[0] || pend[1]); i++) tick();
    if (m_busy || pend[0] || pend[1]) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_log();
    grants.delete();
    results.delete();
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 2; i++) begin p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; end
    rr = 2'b11; m_busy = 0; m_last = 1; m_g = 0; m_age = 0; m_data = '0;
    rst = 1'b1; rst_drv = 1'b1;
    req_vld = '0; rsp_rdy = '0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Reset state, with both requesters asserting: nothing may be accepted.
    set_req(0, OP_ADD, 8'h01, 8'h01);
    set_req(1, OP_ADD, 8'h02, 8'h02);
    tick();
    check("rst_rsp_data", {16'd0, rsp_data}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    pend[0] = 0; pend[1] = 0;
    rst_drv = 0;
    tick();

    // Lone requester 0: ADD 0xFF + 0x01 with carry into bit 8.
    clear_log();
    set_req(0, OP_ADD, 8'hFF, 8'h01);
    run_until_idle(20);
    check("t1_n", results.size(), 1);
    if (results.size() >= 1) check("t1_data", {16'd0, results[0]}, 32'h0100);

    // Tie right after reset: requester 0 first, then requester 1.
    rst_drv = 1; tick(); rst_drv = 0;
    clear_log();
    set_req(0, OP_LSH, 8'h81, 8'd4);
    set_req(1, OP_XOR, 8'hF0, 8'h3C);
    run_until_idle(30);
    check("t2_n", results.size(), 2);
    if (results.size() >= 2) begin
      check("t2_g0", grants[0], 0);
      check("t2_g1", grants[1], 1);
      check("t2_r0", {16'd0, results[0]}, 32'h0810);
      check("t2_r1", {16'd0, results[1]}, 32'h00CC);
    end

    // Continuous contention: grants alternate.
    clear_log();
    for (int i = 0; i < 60 && grants.size() < 6; i++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k]) set_req(k, 3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 17)));
      tick();
    end
    pend[0] = 0; pend[1] = 0;
    run_until_idle(20);
    check("t3_n", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("t3_alt", grants[i], i % 2);

    // Held response: rsp_rdy[0] toggling must not complete requester 1's result.
    clear_log();
    set_req(1, OP_RSH, 8'h80, 8'd3);
    for (int i = 0; i < 8; i++) begin
      rr = (i % 2 == 0) ? 2'b01 : 2'b00;
      tick();
    end
    check("t4_held_vld", {30'd0, rsp_vld}, 32'h2);
    check("t4_held_n", results.size(), 0);
    rr = 2'b10;
    run_until_idle(10);
    check("t4_n", results.size(), 1);
    if (results.size() >= 1) check("t4_data", {16'd0, results[0]}, 32'h0010);
    rr = 2'b11;

    // Boundary opcodes/shifts, all on requester 0 so last_grant ends at 0.
    clear_log();
    set_req(0, 3'd7, 8'h12, 8'h34);   run_until_idle(10);
    set_req(0, OP_LSH, 8'hFF, 8'd16); run_until_idle(10);
    set_req(0, OP_LSH, 8'hFF, 8'd15); run_until_idle(10);
    set_req(0, OP_RSH, 8'hFF, 8'd16); run_until_idle(10);
    check("t5_n", results.size(), 4);
    if (results.size() >= 4) begin
      check("t5_op7", {16'd0, results[0]}, 32'h0000);
      check("t5_lsh16", {16'd0, results[1]}, 32'h0000);
      check("t5_lsh15", {16'd0, results[2]}, 32'h8000);
      check("t5_rsh16", {16'd0, results[3]}, 32'h0000);
    end

    // Reset while in RESP aborts the pending response; requester 0 wins the next tie.
    clear_log();
    rr = 2'b00;
    set_req(0, OP_ADD, 8'h10, 8'h20);
    for (int i = 0; i < 4; i++) tick();
    check("t6_in_resp", {30'd0, rsp_vld}, 32'h1);
    rst_drv = 1; tick(); rst_drv = 0;
    tick();
    check("t6_busy", {31'd0, busy}, 32'h0);
    check("t6_vld", {30'd0, rsp_vld}, 32'h0);
    check("t6_none", results.size(), 0);
    clear_log();
    rr = 2'b11;
    set_req(0, OP_XOR, 8'h55, 8'hAA);
    set_req(1, OP_ADD, 8'h01, 8'h02);
    run_until_idle(30);
    check("t6_n", grants.size(), 2);
    if (grants.size() >= 1) check("t6_first", grants[0], 0);

    // Random traffic, backpressure and occasional resets against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0)
          set_req(k, 3'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom));
      rr = 2'($urandom);
      rst_drv = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst_drv = 0;
    rr = 2'b11;
    run_until_idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
